// File: rtl/conversor_bcd.sv
// conversor_bcd: sequential binary-to-BCD converter (double-dabble).
// A start in the idle state captures produto. The block then shifts one bit
// per cycle for LARGURA cycles. The finished BCD value is published on
// digitos together with a one-cycle pronto pulse.
// Optional feature: define CONVERSOR_BCD_7SEG_EN to add the registered
// active-high gfedcba output segmentos, one 7-bit code per digit.
module conversor_bcd #(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LARGURA-1:0]     produto,
  output logic [4*DIGITOS-1:0]   digitos,
  output logic                   ocupado,
  output logic                   pronto
`ifdef CONVERSOR_BCD_7SEG_EN
  ,
  output logic [7*DIGITOS-1:0]   segmentos
`endif
);

  localparam int CNT_W = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {
    OCIOSO,
    DESLOCA,
    FIM
  } estado_t;

  estado_t               estado_q,  estado_d;
  logic [LARGURA-1:0]    desloc_q,  desloc_d;
  logic [4*DIGITOS-1:0]  acum_q,    acum_d;
  logic [CNT_W-1:0]      cont_q,    cont_d;
  logic [4*DIGITOS-1:0]  digitos_q, digitos_d;
  logic                  ocupado_q, ocupado_d;
  logic                  pronto_q,  pronto_d;
  logic [4*DIGITOS-1:0]  acum_aj;

`ifdef CONVERSOR_BCD_7SEG_EN
  logic [7*DIGITOS-1:0]  segmentos_q, segmentos_d;

  // Active-high gfedcba pattern for one BCD digit; non-decimal codes stay dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction
`endif

  // Double-dabble correction: add 3 to each accumulator digit that is 5 or more.
  always_comb begin
    acum_aj = acum_q;
    for (int i = 0; i < DIGITOS; i++) begin
      if (acum_q[4*i +: 4] >= 4'd5) begin
        acum_aj[4*i +: 4] = acum_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and next-output logic of the OCIOSO/DESLOCA/FIM sequencer.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    estado_d  = estado_q;
    desloc_d  = desloc_q;
    acum_d    = acum_q;
    cont_d    = cont_q;
    digitos_d = digitos_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
`ifdef CONVERSOR_BCD_7SEG_EN
    segmentos_d = segmentos_q;
`endif
    unique case (estado_q)
      OCIOSO: begin
        if (start) begin
          desloc_d  = produto;
          acum_d    = '0;
          cont_d    = CNT_W'(LARGURA);
          estado_d  = DESLOCA;
          ocupado_d = 1'b1;
        end
      end
      DESLOCA: begin
        // Shift {accumulator, shift register} left by one through the corrected digits.
        acum_d   = (acum_aj << 1) | {{(4*DIGITOS-1){1'b0}}, desloc_q[LARGURA-1]};
        desloc_d = desloc_q << 1;
        cont_d   = cont_q - 1'b1;
        if (cont_q == CNT_W'(1)) begin
          // Last shift: the finished value goes straight to the output register,
          // so digitos never shows a partial result.
          estado_d  = FIM;
          digitos_d = acum_d;
          pronto_d  = 1'b1;
`ifdef CONVERSOR_BCD_7SEG_EN
          for (int i = 0; i < DIGITOS; i++) begin
            segmentos_d[7*i +: 7] = seg7(acum_d[4*i +: 4]);
          end
`endif
        end
      end
      FIM: begin
        estado_d  = OCIOSO;
        ocupado_d = 1'b0;
      end
      default: begin
        estado_d  = OCIOSO;
        ocupado_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion and clears everything.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      estado_q  <= OCIOSO;
      desloc_q  <= '0;
      acum_q    <= '0;
      cont_q    <= '0;
      digitos_q <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
`ifdef CONVERSOR_BCD_7SEG_EN
      segmentos_q <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      desloc_q  <= desloc_d;
      acum_q    <= acum_d;
      cont_q    <= cont_d;
      digitos_q <= digitos_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
`ifdef CONVERSOR_BCD_7SEG_EN
      segmentos_q <= segmentos_d;
`endif
    end
  end

  assign digitos = digitos_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
`ifdef CONVERSOR_BCD_7SEG_EN
  assign segmentos = segmentos_q;
`endif

endmodule

// File: tb/tb_conversor_bcd.sv
// tb_conversor_bcd: directed self-checking bench for conversor_bcd (defaults 16/5).
module tb_conversor_bcd;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] produto = '0;
  logic [19:0] digitos;
  logic        ocupado;
  logic        pronto;
`ifdef CONVERSOR_BCD_7SEG_EN
  logic [34:0] segmentos;
`endif

  int n_pass  = 0;
  int n_total = 0;

  conversor_bcd #(.LARGURA(16), .DIGITOS(5)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .produto (produto),
    .digitos (digitos),
    .ocupado (ocupado),
    .pronto  (pronto)
`ifdef CONVERSOR_BCD_7SEG_EN
    ,
    .segmentos (segmentos)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One conversion: start for one edge, then sample every falling edge.
  // idx 1 is the falling edge right after the start edge.
  task automatic run_conv(input logic [15:0] val, input int chg_idx,
                          input logic [15:0] chg_val, output int lat,
                          output int busy, output int npr, output logic [19:0] res);
    @(negedge clock);
    produto = val;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0; busy = 0; npr = 0; res = '0;
    for (int idx = 1; idx <= 40; idx++) begin
      if (idx == chg_idx) produto = chg_val;
      if (ocupado) busy++;
      if (pronto) begin
        npr++;
        if (lat == 0) begin
          lat = idx;
          res = digitos;
        end
      end
      if (lat != 0 && idx == lat + 1) break;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_total++;
    if (digitos !== 20'h0) $display("FAIL reset_digitos: got %h want 00000", digitos);
    else n_pass++;
    n_total++;
    if (ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b want 0", ocupado);
    else n_pass++;
    n_total++;
    if (pronto !== 1'b0) $display("FAIL reset_pronto: got %b want 0", pronto);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_conversions();
    logic [15:0] vin  [3] = '{16'd11520, 16'd0, 16'd65535};
    logic [19:0] vexp [3] = '{20'h11520, 20'h00000, 20'h65535};
    int lat, busy, npr;
    logic [19:0] res;
    for (int k = 0; k < 3; k++) begin
      run_conv(vin[k], 0, 16'd0, lat, busy, npr, res);
      n_total++;
      if (lat !== 17) $display("FAIL conv%0d_latency: got %0d want 17", k, lat);
      else n_pass++;
      n_total++;
      if (busy !== 17) $display("FAIL conv%0d_ocupado_cycles: got %0d want 17", k, busy);
      else n_pass++;
      n_total++;
      if (npr !== 1) $display("FAIL conv%0d_pronto_pulses: got %0d want 1", k, npr);
      else n_pass++;
      n_total++;
      if (res !== vexp[k]) $display("FAIL conv%0d_digitos: got %h want %h", k, res, vexp[k]);
      else n_pass++;
    end
    // Idle with start low: digitos holds even as produto moves.
    produto = 16'd1234;
    repeat (5) @(negedge clock);
    n_total++;
    if (digitos !== 20'h65535 || ocupado !== 1'b0)
      $display("FAIL idle_hold: got digitos=%h ocupado=%b want 65535/0", digitos, ocupado);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pidx [3] = '{0, 0, 0};
    logic [19:0] pdig [3] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
    int np = 0;
    logic occ18 = 1'b1;
    int waited = 0;
    @(negedge clock);
    produto = 16'd9;
    start   = 1'b1;
    for (int idx = 1; idx <= 60; idx++) begin
      @(negedge clock);
      if (idx == 18) occ18 = ocupado;
      if (pronto) begin
        if (np < 3) begin
          pidx[np] = idx;
          pdig[np] = digitos;
        end
        np++;
      end
    end
    start = 1'b0;
    while (ocupado && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    n_total++;
    if (np !== 3) $display("FAIL b2b_pronto_count: got %0d want 3", np);
    else n_pass++;
    n_total++;
    if (pidx[0] !== 17) $display("FAIL b2b_first_latency: got %0d want 17", pidx[0]);
    else n_pass++;
    n_total++;
    if (pidx[1] - pidx[0] !== 18 || pidx[2] - pidx[1] !== 18)
      $display("FAIL b2b_spacing: got %0d,%0d want 18,18", pidx[1] - pidx[0], pidx[2] - pidx[1]);
    else n_pass++;
    n_total++;
    if (pdig[0] !== 20'h00009 || pdig[2] !== 20'h00009)
      $display("FAIL b2b_digitos: got %h,%h want 00009,00009", pdig[0], pdig[2]);
    else n_pass++;
    n_total++;
    if (occ18 !== 1'b0) $display("FAIL b2b_idle_gap: got ocupado=%b want 0", occ18);
    else n_pass++;
    n_total++;
    if (ocupado !== 1'b0) $display("FAIL b2b_drain: got ocupado=%b want 0 after %0d cycles", ocupado, waited);
    else n_pass++;
  endtask

  task automatic test_produto_change();
    int lat, busy, npr;
    logic [19:0] res;
    run_conv(16'd11520, 5, 16'd1, lat, busy, npr, res);
    n_total++;
    if (res !== 20'h11520) $display("FAIL produto_change_digitos: got %h want 11520", res);
    else n_pass++;
    n_total++;
    if (lat !== 17) $display("FAIL produto_change_latency: got %0d want 17", lat);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat, busy, npr;
    int late_pronto = 0;
    logic [19:0] res;
    logic dig_nonzero = 1'b0;
    @(negedge clock);
    produto = 16'd11520;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    n_total++;
    if (ocupado !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", ocupado);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (digitos !== 20'h0 || ocupado !== 1'b0 || pronto !== 1'b0)
      $display("FAIL abort_outputs: got digitos=%h ocupado=%b pronto=%b want 0/0/0",
               digitos, ocupado, pronto);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (pronto) late_pronto++;
      if (digitos !== 20'h0) dig_nonzero = 1'b1;
    end
    n_total++;
    if (late_pronto !== 0 || dig_nonzero !== 1'b0)
      $display("FAIL abort_no_pronto: got pronto_pulses=%0d digitos_changed=%b want 0/0",
               late_pronto, dig_nonzero);
    else n_pass++;
    run_conv(16'd42, 0, 16'd0, lat, busy, npr, res);
    n_total++;
    if (res !== 20'h00042 || lat !== 17)
      $display("FAIL abort_restart: got digitos=%h latency=%0d want 00042/17", res, lat);
    else n_pass++;
  endtask

`ifdef CONVERSOR_BCD_7SEG_EN
  task automatic test_seg7();
    int lat, busy, npr;
    logic [19:0] res;
    run_conv(16'd10, 0, 16'd0, lat, busy, npr, res);
    n_total++;
    if (segmentos !== {7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h3F})
      $display("FAIL seg7_ten: got %h want %h", segmentos, {7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h3F});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_conversions();
    test_back_to_back();
    test_produto_change();
    test_reset_abort();
`ifdef CONVERSOR_BCD_7SEG_EN
    test_seg7();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conversor_bcd.md
CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 Parameter LARGURA, default 16: width of the binary input in bits.
REQ-002 Parameter DIGITOS, default 5: number of BCD output digits; 10^DIGITOS SHALL exceed 2^LARGURA-1.
REQ-003 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request conversion of produto; sampled on the rising clock edge.
REQ-006 produto  input  LARGURA  unsigned binary value, e.g. product from the sequential multiplier.
REQ-007 digitos  output  4*DIGITOS  BCD result, digit 0 in bits [3:0], most significant digit at the top.
REQ-008 ocupado  output  1  high while a conversion is in progress.
REQ-009 pronto  output  1  one-cycle pulse marking that digitos has just been updated.

Function
REQ-010 The block SHALL implement a 3-state FSM: OCIOSO, DESLOCA, FIM.
REQ-011 In OCIOSO with start=1 at an edge, the block SHALL:
- latch produto into an internal shift register;
- clear the internal BCD accumulator;
- load the iteration counter with LARGURA;
- enter DESLOCA.
REQ-012 In OCIOSO with start=0, the block SHALL remain in OCIOSO, and digitos SHALL hold its value.
REQ-013 Each DESLOCA cycle SHALL perform double-dabble:
- add 3 to every accumulator digit >= 5;
- shift {accumulator, shift register} left by one bit;
- decrement the counter.
REQ-014 DESLOCA SHALL run exactly LARGURA cycles, then enter FIM.
REQ-015 In FIM, digitos SHALL load the accumulator, pronto SHALL be 1 for that single cycle, and the next state SHALL be OCIOSO.
REQ-016 Latency SHALL be LARGURA+1 cycles: the start edge to the edge where pronto is seen high (17 cycles with the defaults).
REQ-017 ocupado SHALL be 1 in DESLOCA and FIM, and 0 in OCIOSO.
REQ-018 start in DESLOCA or FIM SHALL be ignored; there is no queueing.
- A new conversion needs start high in OCIOSO, earliest one cycle after pronto.
REQ-019 Changes on produto after the start edge SHALL NOT affect the conversion in progress.
REQ-020 digitos SHALL hold the last completed result until the next FIM; partial results SHALL never appear on digitos.
REQ-021 Every digit of digitos SHALL always be in the range 0-9.

Reset
REQ-022 While reset=1, the block SHALL enter OCIOSO immediately and set digitos=0, ocupado=0, pronto=0, with the shift register, accumulator and counter cleared.
REQ-023 Reset during DESLOCA or FIM SHALL abort the conversion; digitos SHALL read 0, and no pronto pulse SHALL follow.
REQ-024 The first edge after reset deasserts SHALL be treated as OCIOSO, and start is honoured on that edge.

Configuration
REQ-025 Macro CONVERSOR_BCD_7SEG_EN SHALL select the 7-segment output feature.
REQ-026 With the macro defined, an extra output segmentos (7*DIGITOS bits) SHALL be present:
- one active-high gfedcba code per digit, registered together with digitos;
- codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F;
- reset value 0.
REQ-027 Without the macro, the segmentos port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 produto=11520 (120*96), start pulsed one cycle -> ocupado high for 17 cycles; pronto at cycle 17; digitos=0x11520.
REQ-029 produto=0 -> digitos=0x00000 after 17 cycles; produto=65535 -> digitos=0x65535.
REQ-030 start held high continuously with produto=9 -> conversions back-to-back, each pronto 18 cycles apart; digitos=0x00009; start ignored while ocupado=1.
REQ-031 produto changed from 11520 to 1 at cycle 5 of a conversion -> result still 0x11520.
REQ-032 reset asserted at cycle 8 of a conversion, mid-cycle -> outputs 0 immediately, no pronto; a new start with produto=42 -> digitos=0x00042.
REQ-033 With CONVERSOR_BCD_7SEG_EN and produto=10 -> segmentos digits 0 and 1 = 0x3F and 0x06, digits 2-4 = 0x3F.
